// File: rtl/zxbus_ctrl_if.sv
// rtl/zxbus_ctrl_if.sv - Z80 I/O bus bundle between the CPU side and zxbus_ctrl
interface zxbus_ctrl_if;
    logic [15:0] za;
    logic [7:0]  zd_in;
    logic [7:0]  zd_out;
    logic        zd_oe;
    logic        ziorq_n;
    logic        zrd_n;
    logic        zwr_n;
    logic        ziorqge;

    modport master (
        output za, zd_in, ziorq_n, zrd_n, zwr_n,
        input  zd_out, zd_oe, ziorqge
    );

    modport slave (
        input  za, zd_in, ziorq_n, zrd_n, zwr_n,
        output zd_out, zd_oe, ziorqge
    );
endinterface

// File: rtl/zxbus_ctrl.sv
// rtl/zxbus_ctrl.sv - ZX-bus control/status port: decode, W5300/SL811 reset pulses, merged interrupt
module zxbus_ctrl #(
    parameter logic [7:0]  PORT_LO = 8'hAB,
    parameter int unsigned RST_LEN = 64
) (
    input  logic        fclk,
    input  logic        rst,
    zxbus_ctrl_if.slave bus,
    input  logic        eint_n,
    input  logic        uint,
    output logic        zint_n,
    output logic        erst_n,
    output logic        urst_n,
    output logic        ums,
    output logic        ena
);
    localparam logic [7:0] REG_CTRL  = 8'h81;
    localparam logic [7:0] REG_INTEN = 8'h82;
    localparam logic [7:0] REG_STAT  = 8'h83;
    localparam logic [7:0] LEN8      = 8'(RST_LEN);

    logic       ena_q, ena_d, ums_q, ums_d, eie_q, eie_d, uie_q, uie_d;
    logic       iow_s1_q, iow_s1_d, iow_s2_q, iow_s2_d, iow_s3_q, iow_s3_d;
    logic       seen_q, seen_d, armed_q, armed_d;
    logic       eint_s1_q, eint_s1_d, epend_q, epend_d;
    logic       uint_s1_q, uint_s1_d, upend_q, upend_d;
    logic [7:0] ecnt_q, ecnt_d, ucnt_q, ucnt_d;
    logic       zint_n_q, zint_n_d;

    logic       match, iow, wr_stb, ebusy, ubusy;
    logic [7:0] rd_data;

    assign match  = (bus.za[7:0] == PORT_LO) &&
                    (bus.za[15:8] inside {REG_CTRL, REG_INTEN, REG_STAT});
    assign iow    = ~bus.ziorq_n & ~bus.zwr_n;
    // armed_q blocks a strobe that was already active across reset until it has been seen low
    assign wr_stb = iow_s2_q & ~iow_s3_q & armed_q;
    assign ebusy  = (ecnt_q != 8'd0);
    assign ubusy  = (ucnt_q != 8'd0);

    always_comb begin
        ena_d     = ena_q;
        ums_d     = ums_q;
        eie_d     = eie_q;
        uie_d     = uie_q;
        iow_s1_d  = iow;
        iow_s2_d  = iow_s1_q;
        iow_s3_d  = iow_s2_q;
        seen_d    = 1'b1;
        armed_d   = armed_q | (seen_q & ~iow_s1_q);
        eint_s1_d = ~eint_n;
        epend_d   = eint_s1_q;
        uint_s1_d = uint;
        upend_d   = uint_s1_q;
        ecnt_d    = ebusy ? ecnt_q - 8'd1 : ecnt_q;
        ucnt_d    = ubusy ? ucnt_q - 8'd1 : ucnt_q;
        zint_n_d  = ~(ena_q & ((epend_q & eie_q) | (upend_q & uie_q)));

        // A reload placed after the decrement wins over a coincident terminal count
        if (wr_stb && match) begin
            case (bus.za[15:8])
                REG_CTRL: begin
                    ena_d = bus.zd_in[0];
                    ums_d = bus.zd_in[1];
                    if (bus.zd_in[2]) ecnt_d = LEN8;
                    if (bus.zd_in[3]) ucnt_d = LEN8;
                end
                REG_INTEN: begin
                    eie_d = bus.zd_in[0];
                    uie_d = bus.zd_in[1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            ena_q     <= 1'b0;
            ums_q     <= 1'b0;
            eie_q     <= 1'b0;
            uie_q     <= 1'b0;
            iow_s1_q  <= 1'b0;
            iow_s2_q  <= 1'b0;
            iow_s3_q  <= 1'b0;
            seen_q    <= 1'b0;
            armed_q   <= 1'b0;
            eint_s1_q <= 1'b0;
            epend_q   <= 1'b0;
            uint_s1_q <= 1'b0;
            upend_q   <= 1'b0;
            ecnt_q    <= LEN8;
            ucnt_q    <= LEN8;
            zint_n_q  <= 1'b1;
        end else begin
            ena_q     <= ena_d;
            ums_q     <= ums_d;
            eie_q     <= eie_d;
            uie_q     <= uie_d;
            iow_s1_q  <= iow_s1_d;
            iow_s2_q  <= iow_s2_d;
            iow_s3_q  <= iow_s3_d;
            seen_q    <= seen_d;
            armed_q   <= armed_d;
            eint_s1_q <= eint_s1_d;
            epend_q   <= epend_d;
            uint_s1_q <= uint_s1_d;
            upend_q   <= upend_d;
            ecnt_q    <= ecnt_d;
            ucnt_q    <= ucnt_d;
            zint_n_q  <= zint_n_d;
        end
    end

    always_comb begin
        rd_data = 8'hFF;
        if (match) begin
            case (bus.za[15:8])
                REG_CTRL:  rd_data = {6'd0, ums_q, ena_q};
                REG_INTEN: rd_data = {6'd0, uie_q, eie_q};
                REG_STAT:  rd_data = {4'd0, ubusy, ebusy, upend_q, epend_q};
                default:   rd_data = 8'hFF;
            endcase
        end
    end

    assign bus.zd_out  = rd_data;
    assign bus.zd_oe   = match & ~bus.ziorq_n & ~bus.zrd_n;
    assign bus.ziorqge = match & ~bus.ziorq_n;

    assign zint_n = zint_n_q;
    assign erst_n = ~ebusy;
    assign urst_n = ~ubusy;
    assign ums    = ums_q;
    assign ena    = ena_q;
endmodule

// File: tb/tb_zxbus_ctrl.sv
// tb/tb_zxbus_ctrl.sv - randomized bench for zxbus_ctrl against a cycle-timeline reference model
module tb_zxbus_ctrl;
    localparam int RST_LEN = 64;

    logic fclk = 1'b0;
    logic rst  = 1'b1;
    logic eint_n = 1'b1;
    logic uint = 1'b0;
    logic zint_n, erst_n, urst_n, ums, ena;

    zxbus_ctrl_if bus ();

    zxbus_ctrl #(.PORT_LO(8'hAB), .RST_LEN(RST_LEN)) dut (
        .fclk(fclk), .rst(rst), .bus(bus), .eint_n(eint_n), .uint(uint),
        .zint_n(zint_n), .erst_n(erst_n), .urst_n(urst_n), .ums(ums), .ena(ena)
    );

    always #5 fclk = ~fclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register values plus absolute cycle numbers at which reset pulses end
    typedef struct { int at; logic [15:0] a; logic [7:0] d; } wr_t;
    wr_t pend[$];
    int  cyc = 0;
    int  e_end = RST_LEN, u_end = RST_LEN;
    bit  m_ena = 0, m_ums = 0, m_eie = 0, m_uie = 0;
    bit  m_e1 = 0, m_u1 = 0, m_epend = 0, m_upend = 0, m_zint_n = 1;
    bit  m_need_low = 1, m_prev = 1;

    function automatic bit m_match(input logic [15:0] a);
        return a[7:0] == 8'hAB && a[15:8] >= 8'h81 && a[15:8] <= 8'h83;
    endfunction

    function automatic logic [7:0] m_read(input logic [15:0] a);
        if (!m_match(a)) return 8'hFF;
        case (a[15:8])
            8'h81:   return {6'd0, m_ums, m_ena};
            8'h82:   return {6'd0, m_uie, m_eie};
            default: return {4'd0, cyc < u_end, cyc < e_end, m_upend, m_epend};
        endcase
    endfunction

    task automatic model_step();
        bit iow, znew;
        wr_t w;
        cyc++;
        iow = !bus.ziorq_n && !bus.zwr_n;
        if (rst) begin
            {m_ena, m_ums, m_eie, m_uie} = '0;
            {m_e1, m_u1, m_epend, m_upend} = '0;
            m_zint_n = 1;
            e_end = cyc + RST_LEN;
            u_end = cyc + RST_LEN;
            pend.delete();
            m_need_low = 1;
            m_prev = 1;
        end else begin
            znew = !(m_ena && ((m_epend && m_eie) || (m_upend && m_uie)));
            m_epend = m_e1; m_e1 = !eint_n;
            m_upend = m_u1; m_u1 = uint;
            m_zint_n = znew;
            if (iow && !m_prev && !m_need_low) pend.push_back('{cyc + 2, bus.za, bus.zd_in});
            if (!iow) m_need_low = 0;
            m_prev = iow;
            while (pend.size() > 0 && pend[0].at == cyc) begin
                w = pend.pop_front();
                if (m_match(w.a)) begin
                    if (w.a[15:8] == 8'h81) begin
                        m_ena = w.d[0];
                        m_ums = w.d[1];
                        if (w.d[2]) e_end = cyc + RST_LEN;
                        if (w.d[3]) u_end = cyc + RST_LEN;
                    end else if (w.a[15:8] == 8'h82) begin
                        m_eie = w.d[0];
                        m_uie = w.d[1];
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge fclk);
        model_step();
    end

    // Per-cycle compare of every output against the model
    initial forever begin
        @(negedge fclk);
        if (cyc >= 1) begin
            check("erst_n", {7'd0, erst_n}, {7'd0, cyc >= e_end});
            check("urst_n", {7'd0, urst_n}, {7'd0, cyc >= u_end});
            check("ena", {7'd0, ena}, {7'd0, m_ena});
            check("ums", {7'd0, ums}, {7'd0, m_ums});
            check("zint_n", {7'd0, zint_n}, {7'd0, m_zint_n});
            check("ziorqge", {7'd0, bus.ziorqge}, {7'd0, m_match(bus.za) && !bus.ziorq_n});
            check("zd_oe", {7'd0, bus.zd_oe}, {7'd0, m_match(bus.za) && !bus.ziorq_n && !bus.zrd_n});
            check("zd_out", bus.zd_out, m_read(bus.za));
        end
    end

    // Low-run lengths of the reset outputs, counted only outside rst
    int eruns[$], uruns[$];
    int elen = 0, ulen = 0;
    initial forever begin
        @(negedge fclk);
        if (cyc >= 1 && !rst) begin
            if (!erst_n) elen++;
            else if (elen > 0) begin eruns.push_back(elen); elen = 0; end
            if (!urst_n) ulen++;
            else if (ulen > 0) begin uruns.push_back(ulen); ulen = 0; end
        end
    end

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int len);
        bus.za = a; bus.zd_in = d;
        bus.ziorq_n = 1'b0; bus.zwr_n = 1'b0;
        idle(len);
        bus.ziorq_n = 1'b1; bus.zwr_n = 1'b1;
        idle(3);
    endtask

    task automatic bus_read_start(input logic [15:0] a);
        bus.za = a;
        bus.ziorq_n = 1'b0; bus.zrd_n = 1'b0;
    endtask

    task automatic bus_release();
        bus.ziorq_n = 1'b1; bus.zrd_n = 1'b1; bus.zwr_n = 1'b1;
    endtask

    initial begin
        bus.za = 16'h0000; bus.zd_in = 8'h00;
        bus.ziorq_n = 1'b1; bus.zrd_n = 1'b1; bus.zwr_n = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge fclk);
        check("lit_reset_zint_n", {7'd0, zint_n}, 8'd1);
        check("lit_reset_ena", {7'd0, ena}, 8'd0);
        check("lit_reset_erst_n", {7'd0, erst_n}, 8'd0);
        idle(70);

        bus_write(16'h81AB, 8'h07, 6);
        check("lit_ctrl_ena", {7'd0, ena}, 8'd1);
        check("lit_ctrl_ums", {7'd0, ums}, 8'd1);
        bus_read_start(16'h81AB);
        @(negedge fclk);
        check("lit_ctrl_read", bus.zd_out, 8'h03);
        check("lit_ctrl_oe", {7'd0, bus.zd_oe}, 8'd1);
        tick(); bus_release();
        idle(70);

        bus_write(16'h81AB, 8'h07, 4);
        idle(23);
        bus_write(16'h81AB, 8'h07, 4);
        idle(100);

        bus_write(16'h81AB, 8'h01, 4);
        bus_write(16'h82AB, 8'h01, 4);
        eint_n = 1'b0;
        idle(2);
        @(negedge fclk);
        check("lit_int_before", {7'd0, zint_n}, 8'd1);
        tick();
        @(negedge fclk);
        check("lit_int_3rd_edge", {7'd0, zint_n}, 8'd0);
        bus_read_start(16'h83AB);
        @(negedge fclk);
        check("lit_stat_read", bus.zd_out, 8'h01);
        tick(); bus_release();
        eint_n = 1'b1;
        idle(4);
        uint = 1'b1;
        idle(4);
        @(negedge fclk);
        check("lit_uint_masked", {7'd0, zint_n}, 8'd1);
        eint_n = 1'b0;
        idle(4);
        bus_write(16'h81AB, 8'h00, 4);
        idle(2);
        @(negedge fclk);
        check("lit_ena_off", {7'd0, zint_n}, 8'd1);
        eint_n = 1'b1; uint = 1'b0;

        bus_read_start(16'h84AB);
        @(negedge fclk);
        check("lit_miss_oe", {7'd0, bus.zd_oe}, 8'd0);
        check("lit_miss_ge", {7'd0, bus.ziorqge}, 8'd0);
        check("lit_miss_data", bus.zd_out, 8'hFF);
        tick();
        bus.za = 16'h81AC;
        @(negedge fclk);
        check("lit_miss_lo_ge", {7'd0, bus.ziorqge}, 8'd0);
        tick(); bus_release();
        bus_write(16'h84AB, 8'hFF, 4);
        bus_write(16'h81AC, 8'hFF, 4);
        check("lit_miss_ena", {7'd0, ena}, 8'd0);
        idle(5);

        bus_write(16'h81AB, 8'h04, 2);
        idle(70);
        bus_write(16'h81AB, 8'h04, 50);
        idle(70);

        bus.za = 16'h81AB; bus.zd_in = 8'h03;
        bus.ziorq_n = 1'b0; bus.zwr_n = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(6);
        bus_release();
        idle(3);
        check("lit_rst_strobe_ena", {7'd0, ena}, 8'd0);
        idle(70);

        check("lit_erun_count", 8'(eruns.size()), 8'd6);
        if (eruns.size() >= 6) begin
            check("lit_erun_reset", 8'(eruns[0]), 8'd64);
            check("lit_erun_write", 8'(eruns[1]), 8'd64);
            check("lit_erun_restart", 8'(eruns[2]), 8'd94);
            check("lit_erun_short", 8'(eruns[3]), 8'd64);
            check("lit_erun_long", 8'(eruns[4]), 8'd64);
            check("lit_erun_midrst", 8'(eruns[5]), 8'd64);
        end
        check("lit_urun_count", 8'(uruns.size()), 8'd2);

        for (int i = 0; i < 250; i++) begin
            int op;
            logic [15:0] a;
            op = $urandom_range(0, 9);
            a[15:8] = 8'h80 + 8'($urandom_range(0, 5));
            a[7:0]  = ($urandom_range(0, 7) == 0) ? 8'hAC : 8'hAB;
            case (op)
                0, 1, 2, 3: bus_write(a, 8'($urandom), $urandom_range(1, 6));
                4, 5: begin
                    bus_read_start(a);
                    idle($urandom_range(1, 3));
                    bus_release();
                    tick();
                end
                6: begin eint_n = ~eint_n; tick(); end
                7: begin uint = ~uint; tick(); end
                8: idle($urandom_range(1, 5));
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        rst = 1'b1;
                        idle($urandom_range(1, 2));
                        rst = 1'b0;
                    end
                    tick();
                end
            endcase
        end
        idle(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
